// File: rtl/dcm_lock_ctrl.sv
// dcm_lock_ctrl: pulses the DCM reset, waits for a clean lock, and holds SYS_RST until the clock has settled.
module dcm_lock_ctrl #(
    parameter int RST_PULSE    = 4,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SETTLE       = 64,
    parameter int MAX_RETRY    = 3
) (
    input  logic       CLKIN,
    input  logic       RST,
    input  logic       LOCKED,
    input  logic [7:0] STATUS,
    output logic       DCM_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT
);
    typedef enum logic [2:0] {st_pulse, st_wait, st_settle, st_run, st_fault} state_t;

    localparam logic [15:0] pulse_last  = 16'(RST_PULSE - 1);
    localparam logic [15:0] lock_last   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] settle_last = 16'(SETTLE - 1);
    localparam logic [3:0]  retry_max   = 4'(MAX_RETRY);

    logic [1:0]  lk_q, fs_q;
    logic        good, fail;
    logic        unused_status;
    state_t      state, nxt;
    logic [15:0] cnt;
    logic [3:0]  retry, retry_inc, retry_nxt;

    assign unused_status = ^{STATUS[7:3], STATUS[1:0]};
    assign good          = lk_q[1] & ~fs_q[1];
    assign RETRY_COUNT   = retry;

    // bring LOCKED and the CLKFX-stopped flag into the CLKIN domain
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            lk_q <= 2'b00;
            fs_q <= 2'b00;
        end else begin
            lk_q <= {lk_q[0], LOCKED};
            fs_q <= {fs_q[0], STATUS[2]};
        end
    end

    // next state; a lock seen on the timeout cycle wins over the timeout
    always_comb begin
        fail      = 1'b0;
        nxt       = state;
        retry_inc = (retry == 4'hf) ? retry : retry + 4'd1;
        case (state)
            st_pulse:  nxt = (cnt == pulse_last) ? st_wait : st_pulse;
            st_wait: begin
                nxt  = good ? st_settle : st_wait;
                fail = ~good & (cnt == lock_last);
            end
            st_settle: begin
                nxt  = (cnt == settle_last) ? st_run : st_settle;
                fail = ~good;
            end
            st_run:    nxt = good ? st_run : st_pulse;
            default:   nxt = st_fault;
        endcase
        if (fail)
            nxt = (retry_inc == retry_max) ? st_fault : st_pulse;
        retry_nxt = fail ? retry_inc : (nxt == st_run) ? 4'd0 : retry;
    end

    // state, attempt counter and outputs registered from the next state
    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            state   <= st_pulse;
            cnt     <= 16'd0;
            retry   <= 4'd0;
            DCM_RST <= 1'b1;
            SYS_RST <= 1'b1;
            READY   <= 1'b0;
            FAULT   <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= (nxt != state) ? 16'd0 : cnt + 16'd1;
            retry   <= retry_nxt;
            DCM_RST <= (nxt == st_pulse) || (nxt == st_fault);
            SYS_RST <= nxt != st_run;
            READY   <= nxt == st_run;
            FAULT   <= nxt == st_fault;
        end
    end
endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// tb_dcm_lock_ctrl: scoreboard bench; outputs packed as {DCM_RST, SYS_RST, READY, FAULT, RETRY_COUNT}.
module tb_dcm_lock_ctrl;
    logic       CLKIN = 1'b0;
    logic       RST = 1'b1;
    logic       LOCKED = 1'b0;
    logic [7:0] STATUS = 8'h00;
    logic       DCM_RST, SYS_RST, READY, FAULT;
    logic [3:0] RETRY_COUNT;
    logic [7:0] outs;

    typedef struct {
        int         at;
        logic [7:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    localparam logic [7:0] run_v = 8'b0010_0000;

    dcm_lock_ctrl dut (
        .CLKIN(CLKIN), .RST(RST), .LOCKED(LOCKED), .STATUS(STATUS),
        .DCM_RST(DCM_RST), .SYS_RST(SYS_RST), .READY(READY), .FAULT(FAULT),
        .RETRY_COUNT(RETRY_COUNT)
    );

    assign outs = {DCM_RST, SYS_RST, READY, FAULT, RETRY_COUNT};

    always #5 CLKIN = ~CLKIN;

    // edge number since RST fell; edge 1 is the first rising edge after release
    always @(posedge CLKIN) cyc <= RST ? 0 : cyc + 1;

    function automatic logic [7:0] pv(input logic [3:0] rc);
        return {4'b1100, rc};
    endfunction
    function automatic logic [7:0] wv(input logic [3:0] rc);
        return {4'b0100, rc};
    endfunction
    function automatic logic [7:0] fv(input logic [3:0] rc);
        return {4'b1101, rc};
    endfunction

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge CLKIN);
            #1;
        end
    endtask

    task automatic apply_reset;
        @(posedge CLKIN);
        #1;
        RST = 1'b1;
        LOCKED = 1'b0;
        STATUS = 8'h00;
        sb.delete();
        repeat (2) @(posedge CLKIN);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLKIN);
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", outs, 8'hC0);
        end
    endtask

    task automatic test_clean_lock;
        apply_reset();
        sb.push_back('{1, pv(0), "clean_pulse_start"});
        sb.push_back('{3, pv(0), "clean_pulse_hold"});
        sb.push_back('{4, wv(0), "clean_pulse_end"});
        for (int c = 1; c <= 80; c++) begin
            goto(c);
            if (c == 10) begin
                LOCKED = 1'b1;
                sb.push_back('{76, wv(0), "clean_settling"});
                sb.push_back('{77, run_v, "clean_run"});
                sb.push_back('{80, run_v, "clean_run_hold"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clean_lock: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_timeout_retry;
        apply_reset();
        sb.push_back('{4099, wv(0), "to_wait_last"});
        sb.push_back('{4100, pv(1), "to_second_pulse"});
        sb.push_back('{4103, pv(1), "to_pulse_hold"});
        sb.push_back('{4104, wv(1), "to_second_wait"});
        for (int c = 1; c <= 4175; c++) begin
            goto(c);
            if (c == 4104) begin
                LOCKED = 1'b1;
                sb.push_back('{4170, wv(1), "to_settling"});
                sb.push_back('{4171, run_v, "to_run_clears_retry"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_retry: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_timeout_boundary;
        apply_reset();
        for (int c = 1; c <= 4165; c++) begin
            goto(c);
            if (c == 4097) begin
                LOCKED = 1'b1;
                sb.push_back('{4099, wv(0), "tb_wait_last"});
                sb.push_back('{4100, wv(0), "tb_lock_wins"});
                sb.push_back('{4163, wv(0), "tb_settling"});
                sb.push_back('{4164, run_v, "tb_run"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_boundary: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_settle_boundary;
        apply_reset();
        for (int c = 1; c <= 80; c++) begin
            goto(c);
            if (c == 10) LOCKED = 1'b1;
            if (c == 74) begin
                LOCKED = 1'b0;
                sb.push_back('{76, wv(0), "sb_settling"});
                sb.push_back('{77, pv(1), "sb_drop_last_cycle"});
                sb.push_back('{80, pv(1), "sb_pulse_hold"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL settle_boundary: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_run_loss;
        apply_reset();
        for (int c = 1; c <= 165; c++) begin
            goto(c);
            if (c == 10) begin
                LOCKED = 1'b1;
                sb.push_back('{77, run_v, "rl_first_run"});
            end
            if (c == 90) begin
                LOCKED = 1'b0;
                sb.push_back('{92, run_v, "rl_still_run"});
                sb.push_back('{93, pv(0), "rl_sys_rst_rises"});
                sb.push_back('{96, pv(0), "rl_pulse_hold"});
                sb.push_back('{97, wv(0), "rl_pulse_end"});
                sb.push_back('{161, wv(0), "rl_settling"});
                sb.push_back('{162, run_v, "rl_relock_run"});
            end
            if (c == 91) LOCKED = 1'b1;
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL run_loss: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_clkfx_stop;
        apply_reset();
        for (int c = 1; c <= 120; c++) begin
            goto(c);
            if (c == 10) LOCKED = 1'b1;
            if (c == 43) begin
                STATUS = 8'h04;
                sb.push_back('{45, wv(0), "fx_settling"});
                sb.push_back('{46, pv(1), "fx_failed_attempt"});
            end
            if (c == 46) begin
                STATUS = 8'h01;
                sb.push_back('{49, pv(1), "fx_pulse_hold"});
                sb.push_back('{50, wv(1), "fx_wait"});
                sb.push_back('{114, wv(1), "fx_settling2"});
                sb.push_back('{115, run_v, "fx_run"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clkfx_stop: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_mid_reset;
        apply_reset();
        for (int c = 1; c <= 40; c++) begin
            goto(c);
            if (c == 10) LOCKED = 1'b1;
        end
        checks++;
        if (outs !== wv(0)) begin
            errors++;
            $display("FAIL mr_in_settle: got %b expected %b", outs, wv(0));
        end
        #2;
        RST = 1'b1;
        LOCKED = 1'b0;
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++;
            $display("FAIL mr_async_reset: got %b expected %b", outs, 8'hC0);
        end
        repeat (2) @(posedge CLKIN);
        #1;
        RST = 1'b0;
        sb.push_back('{1, pv(0), "mr_pulse_start"});
        sb.push_back('{4, wv(0), "mr_pulse_end"});
        for (int c = 1; c <= 80; c++) begin
            goto(c);
            if (c == 10) begin
                LOCKED = 1'b1;
                sb.push_back('{76, wv(0), "mr_settling"});
                sb.push_back('{77, run_v, "mr_run"});
            end
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_reset: %0d expectations not reached", sb.size());
        end
    endtask

    task automatic test_fault;
        apply_reset();
        sb.push_back('{4100, pv(1), "ft_retry1"});
        sb.push_back('{8200, pv(2), "ft_retry2"});
        sb.push_back('{8204, wv(2), "ft_wait3"});
        sb.push_back('{12299, wv(2), "ft_wait3_last"});
        for (int c = 1; c <= 32300; c++) begin
            goto(c);
            if (c == 13000) LOCKED = 1'b1;
            if (c >= 12300) sb.push_back('{c, fv(3), "ft_fault_hold"});
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].at == c) begin
                checks++;
                if (outs !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s edge %0d: got %b expected %b", sb[i].name, c, outs, sb[i].v);
                end
                sb.delete(i);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fault: %0d expectations not reached", sb.size());
        end
        #2;
        RST = 1'b1;
        LOCKED = 1'b0;
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++;
            $display("FAIL ft_async_reset: got %b expected %b", outs, 8'hC0);
        end
        repeat (2) @(posedge CLKIN);
        #1;
        RST = 1'b0;
        goto(4);
        checks++;
        if (outs !== wv(0)) begin
            errors++;
            $display("FAIL ft_restart: got %b expected %b", outs, wv(0));
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_timeout_retry();
        test_timeout_boundary();
        test_settle_boundary();
        test_run_loss();
        test_clkfx_stop();
        test_mid_reset();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
